// File: rtl/mux_4.sv
// Registered 4-to-1 word mux for datapath steering. Optional out_par flop under MUX4_PARITY_EN.
// Latency: 1 cycle from the capturing clk edge to out/out_sel/out_valid/out_par.
// Backpressure: none; en=0 holds every output, one new selection per cycle otherwise.
module mux_4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  output logic             out_par
);

  logic [WIDTH-1:0] sel_dat;

  // All four codes are legal, so the case is full without a default arm.
  always_comb begin
    sel_dat = in0;
    unique case (sel)
      2'b00: sel_dat = in0;
      2'b01: sel_dat = in1;
      2'b10: sel_dat = in2;
      2'b11: sel_dat = in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= 2'b00;
      out_valid <= 1'b0;
    end else if (en) begin
      out       <= sel_dat;
      out_sel   <= sel;
      out_valid <= 1'b1;
    end
  end

`ifdef MUX4_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (en) begin
      out_par <= ^sel_dat;
    end
  end
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4.sv
// Directed-vector bench for mux_4; parity expectations follow MUX4_PARITY_EN.
module tb_mux_4;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic [1:0]       out_sel;
  logic             out_valid;
  logic             out_par;

  int tests_run = 0;
  int tests_failed = 0;

  mux_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .sel       (sel),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_par   (out_par)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] w);
`ifdef MUX4_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag, input logic [WIDTH-1:0] e_out,
                           input logic [1:0] e_sel, input logic e_vld, input logic e_par);
    check({tag, ".out"},   64'(out),       64'(e_out));
    check({tag, ".sel"},   64'(out_sel),   64'(e_sel));
    check({tag, ".valid"}, 64'(out_valid), 64'(e_vld));
    check({tag, ".par"},   64'(out_par),   64'(e_par));
  endtask

  logic [WIDTH-1:0] sweep_dat [4];

  initial begin
    sweep_dat[0] = 32'hAAAA0000;
    sweep_dat[1] = 32'hBBBB0000;
    sweep_dat[2] = 32'hCCCC0000;
    sweep_dat[3] = 32'hDDDD0000;

    // Reset held for two edges with en=1 must win.
    rst = 1'b1; en = 1'b1; sel = 2'b00;
    in0 = 32'hAAAA0000; in1 = '0; in2 = '0; in3 = '0;
    #1;
    tick();
    tick();
    check_all("reset", 32'h0, 2'b00, 1'b0, 1'b0);

    // en=0 right after reset: valid must stay low.
    rst = 1'b0; en = 1'b0; sel = 2'b11;
    tick();
    check_all("post_rst_hold", 32'h0, 2'b00, 1'b0, 1'b0);

    // Select sweep.
    en = 1'b1;
    in0 = sweep_dat[0]; in1 = sweep_dat[1]; in2 = sweep_dat[2]; in3 = sweep_dat[3];
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      check_all($sformatf("sweep%0d", i), sweep_dat[i], 2'(i), 1'b1, exp_par(sweep_dat[i]));
    end

    // Hold: capture sel=10, then en=0 with sel and in2 changing.
    sel = 2'b10;
    tick();
    check("hold_cap.out", 64'(out), 64'(32'hCCCC0000));
    en = 1'b0; sel = 2'b11; in2 = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("hold%0d", i), 32'hCCCC0000, 2'b10, 1'b1, 1'b0);
    end

    // New sel and new data on the same edge.
    en = 1'b1; sel = 2'b01; in1 = 32'h0000FFFF;
    tick();
    check_all("simul", 32'h0000FFFF, 2'b01, 1'b1, 1'b0);

    // Mid-stream reset with en=1.
    in1 = 32'hBBBB0000; in2 = 32'hCCCC0000;
    sel = 2'b00;
    tick();
    check("mid_pre.out", 64'(out), 64'(32'hAAAA0000));
    rst = 1'b1; sel = 2'b01;
    tick();
    check_all("mid_rst", 32'h0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0; sel = 2'b10;
    tick();
    check_all("mid_resume", 32'hCCCC0000, 2'b10, 1'b1, 1'b0);

    // Parity: odd and even bit counts.
    in0 = 32'h00000001; sel = 2'b00;
    tick();
    check("par_odd.out", 64'(out), 64'(32'h00000001));
    check("par_odd.par", 64'(out_par), 64'(exp_par(32'h00000001)));
    in3 = 32'h00000003; sel = 2'b11;
    tick();
    check("par_even.out", 64'(out), 64'(32'h00000003));
    check("par_even.par", 64'(out_par), 64'(1'b0));

`ifdef MUX4_PARITY_EN
    // Parity must hold with en=0 and clear on reset.
    in0 = 32'h00000001; sel = 2'b00;
    tick();
    en = 1'b0; in0 = 32'h0;
    tick();
    check("par_hold", 64'(out_par), 64'(1'b1));
    rst = 1'b1;
    tick();
    check("par_rst", 64'(out_par), 64'(1'b0));
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
